// File: rtl/update_apply_min_pkg.sv
// Shared definitions for the min-apply update stage: default widths, the
// "unreached" value and the sweep/run state encoding.
package update_apply_min_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned VID_W_DEF  = 10;

    localparam logic [DATA_W_DEF-1:0] INF = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/update_apply_min_if.sv
// Two-lane update bus between the combine stage (master) and the
// min-apply stage (slave), plus the activated-vertex outputs.
interface update_apply_min_if
    import update_apply_min_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              InputValid_A;
    logic              InputValid_B;
    logic [DATA_W-1:0] InDestVid_A;
    logic [DATA_W-1:0] InDestVid_B;
    logic [DATA_W-1:0] InUpdate_A;
    logic [DATA_W-1:0] InUpdate_B;
    logic              InReady;
    logic              OutValid_A;
    logic              OutValid_B;
    logic [DATA_W-1:0] OutDestVid_A;
    logic [DATA_W-1:0] OutDestVid_B;
    logic [DATA_W-1:0] OutValue_A;
    logic [DATA_W-1:0] OutValue_B;
    logic [31:0]       ImproveCount;

    modport master (
        output InputValid_A, InputValid_B, InDestVid_A, InDestVid_B,
               InUpdate_A, InUpdate_B,
        input  InReady, OutValid_A, OutValid_B, OutDestVid_A, OutDestVid_B,
               OutValue_A, OutValue_B, ImproveCount
    );

    modport slave (
        input  InputValid_A, InputValid_B, InDestVid_A, InDestVid_B,
               InUpdate_A, InUpdate_B,
        output InReady, OutValid_A, OutValid_B, OutDestVid_A, OutDestVid_B,
               OutValue_A, OutValue_B, ImproveCount
    );

endinterface

// File: rtl/update_apply_min_vertex_prop_ram.sv
// Vertex property memory: one port per lane, each with its own registered
// read address and write address so a lane can read and write in one cycle.
module vertex_prop_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] waddr_a_i,
    input  logic [DATA_W-1:0] wdata_a_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] waddr_b_i,
    input  logic [DATA_W-1:0] wdata_b_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_a_q;
    logic [DATA_W-1:0] rdata_b_q;

    // Read returns the pre-write contents; callers forward fresh writes.
    always_ff @(posedge clk) begin
        if (we_a_i) mem[waddr_a_i] <= wdata_a_i;
        if (we_b_i) mem[waddr_b_i] <= wdata_b_i;
        rdata_a_q <= mem[raddr_a_i];
        rdata_b_q <= mem[raddr_b_i];
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/update_apply_min.sv
// Two-lane min-apply stage: sweeps the property memory to INF, then keeps
// min(stored, update) per vertex and reports every improvement.
module update_apply_min
    import update_apply_min_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned VID_W  = VID_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    update_apply_min_if.slave bus
);

    localparam int unsigned CNT_W = VID_W - 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run;

    logic [1:0]        in_vld;
    logic [DATA_W-1:0] in_id  [2];
    logic [DATA_W-1:0] in_upd [2];
    logic              same_idx;

    logic [1:0]        s1_vld_d, s1_vld_q, s2_vld_q;
    logic [DATA_W-1:0] s1_upd_d [2];
    logic [DATA_W-1:0] s1_id_q  [2];
    logic [DATA_W-1:0] s1_upd_q [2];
    logic [DATA_W-1:0] s2_id_q  [2];
    logic [DATA_W-1:0] s2_upd_q [2];
    logic [VID_W-1:0]  s1_idx   [2];
    logic [VID_W-1:0]  s2_idx   [2];

    logic [DATA_W-1:0] rd_data  [2];
    logic [DATA_W-1:0] stored   [2];
    logic [1:0]        improve;

    logic [1:0]        fwd_vld_q;
    logic [VID_W-1:0]  fwd_idx_q [2];
    logic [DATA_W-1:0] fwd_val_q [2];

    logic [1:0]        ram_we;
    logic [VID_W-1:0]  ram_waddr [2];
    logic [DATA_W-1:0] ram_wdata [2];

    logic [1:0]        out_vld_q;
    logic [DATA_W-1:0] out_id_q  [2];
    logic [DATA_W-1:0] out_val_q [2];
    logic [31:0]       count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN:  ;
            default: state_d = ST_INIT;
        endcase
    end

    assign run         = (state_q == ST_RUN);
    assign bus.InReady = run;

    assign in_vld[0] = run & bus.InputValid_A;
    assign in_vld[1] = run & bus.InputValid_B;
    assign in_id[0]  = bus.InDestVid_A;
    assign in_id[1]  = bus.InDestVid_B;
    assign in_upd[0] = bus.InUpdate_A;
    assign in_upd[1] = bus.InUpdate_B;

    // Same vertex on both lanes in one cycle collapses into lane A.
    always_comb begin
        same_idx    = in_vld[0] & in_vld[1] &
                      (in_id[0][VID_W-1:0] == in_id[1][VID_W-1:0]);
        s1_vld_d[0] = in_vld[0];
        s1_vld_d[1] = in_vld[1] & ~same_idx;
        s1_upd_d[0] = (same_idx && (in_upd[1] < in_upd[0])) ? in_upd[1] : in_upd[0];
        s1_upd_d[1] = in_upd[1];
    end

    // Compare stage: the memory read misses a write committed on the same
    // edge, so the last cycle's writes from either lane override it.
    always_comb begin
        improve = '0;
        for (int unsigned l = 0; l < 2; l++) begin
            s1_idx[l] = s1_id_q[l][VID_W-1:0];
            s2_idx[l] = s2_id_q[l][VID_W-1:0];
            stored[l] = rd_data[l];
            for (int unsigned m = 0; m < 2; m++) begin
                if (fwd_vld_q[m] && (fwd_idx_q[m] == s2_idx[l])) stored[l] = fwd_val_q[m];
            end
            improve[l] = s2_vld_q[l] && (s2_upd_q[l] < stored[l]);
            if (run) begin
                ram_we[l]    = improve[l];
                ram_waddr[l] = s2_idx[l];
                ram_wdata[l] = s2_upd_q[l];
            end else begin
                ram_we[l]    = 1'b1;
                ram_waddr[l] = {cnt_q, l[0]};
                ram_wdata[l] = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q  <= '0;
            s2_vld_q  <= '0;
            fwd_vld_q <= '0;
            out_vld_q <= '0;
            count_q   <= '0;
            for (int unsigned l = 0; l < 2; l++) begin
                s1_id_q[l]   <= '0;
                s1_upd_q[l]  <= '0;
                s2_id_q[l]   <= '0;
                s2_upd_q[l]  <= '0;
                fwd_idx_q[l] <= '0;
                fwd_val_q[l] <= '0;
                out_id_q[l]  <= '0;
                out_val_q[l] <= '0;
            end
        end else begin
            s1_vld_q  <= s1_vld_d;
            s2_vld_q  <= s1_vld_q;
            fwd_vld_q <= improve;
            out_vld_q <= improve;
            count_q   <= count_q + {31'b0, improve[0]} + {31'b0, improve[1]};
            for (int unsigned l = 0; l < 2; l++) begin
                s1_id_q[l]   <= in_id[l];
                s1_upd_q[l]  <= s1_upd_d[l];
                s2_id_q[l]   <= s1_id_q[l];
                s2_upd_q[l]  <= s1_upd_q[l];
                fwd_idx_q[l] <= s2_idx[l];
                fwd_val_q[l] <= s2_upd_q[l];
                out_id_q[l]  <= improve[l] ? s2_id_q[l]  : '0;
                out_val_q[l] <= improve[l] ? s2_upd_q[l] : '0;
            end
        end
    end

    vertex_prop_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (VID_W)
    ) u_ram (
        .clk       (clk),
        .we_a_i    (ram_we[0]),
        .waddr_a_i (ram_waddr[0]),
        .wdata_a_i (ram_wdata[0]),
        .raddr_a_i (s1_idx[0]),
        .rdata_a_o (rd_data[0]),
        .we_b_i    (ram_we[1]),
        .waddr_b_i (ram_waddr[1]),
        .wdata_b_i (ram_wdata[1]),
        .raddr_b_i (s1_idx[1]),
        .rdata_b_o (rd_data[1])
    );

    assign bus.OutValid_A   = out_vld_q[0];
    assign bus.OutValid_B   = out_vld_q[1];
    assign bus.OutDestVid_A = out_id_q[0];
    assign bus.OutDestVid_B = out_id_q[1];
    assign bus.OutValue_A   = out_val_q[0];
    assign bus.OutValue_B   = out_val_q[1];
    assign bus.ImproveCount = count_q;

endmodule

// File: doc/update_apply_min.md
UPDATE_APPLY_MIN -- requirements
Module: update_apply_min

Interface
REQ-001 Parameter DATA_W, default 32, width of vertex IDs and update values.
REQ-002 Parameter VID_W, default 10, vertex index width; property memory depth 2^VID_W; index = InDestVid[VID_W-1:0].
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 InputValid_A / InputValid_B  in  1  lane A/B update valid (from combine stage).
REQ-006 InDestVid_A / InDestVid_B  in  DATA_W  lane A/B destination vertex ID.
REQ-007 InUpdate_A / InUpdate_B  in  DATA_W  lane A/B candidate value (unsigned).
REQ-008 InReady  out  1  high when updates are accepted; low during init sweep.
REQ-009 OutValid_A / OutValid_B  out  1  lane A/B vertex value improved (activated vertex).
REQ-010 OutDestVid_A / OutDestVid_B  out  DATA_W  improved vertex ID.
REQ-011 OutValue_A / OutValue_B  out  DATA_W  new stored value.
REQ-012 ImproveCount  out  32  running count of improvements since init completed.

Function
REQ-013 Block SHALL keep a 2^VID_W x DATA_W vertex property memory, two ports, synchronous read, one port per lane.
REQ-014 FSM SHALL have states INIT and RUN; INIT entered on reset release.
REQ-015 In INIT, an address counter SHALL write all-ones (INF) to one address per cycle on both ports (A even, B odd), InReady=0; after 2^(VID_W-1) cycles SHALL go to RUN.
REQ-016 In RUN, InReady=1; inputs with InputValid high SHALL be accepted every cycle, no backpressure.
REQ-017 InputValid asserted while InReady=0 SHALL be ignored, no state change.
REQ-018 Update sampled at edge k: memory read at edge k+1; compare/write at edge k+2; Out* registered at edge k+2 (2-cycle latency).
REQ-019 Apply rule: new = min(stored, update); if update < stored, write update, assert OutValid with ID/value, increment ImproveCount; otherwise no write, OutValid=0.
REQ-020 Same index on both lanes in the same input cycle: lane B SHALL be merged into lane A (A update = min(A,B)), lane B dropped; OutValid_B=0 for that item.
REQ-021 RAW hazard: if the compare-stage index matches a write committed at the previous edge (either lane), the forwarded written value SHALL replace the stale memory read.
REQ-022 Matching index on different lanes in consecutive cycles SHALL forward across lanes identically.
REQ-023 ImproveCount SHALL add 0, 1 or 2 per cycle; wraps modulo 2^32.
REQ-024 Out* SHALL be 0 whenever the corresponding OutValid is 0.

Reset
REQ-025 While rst=0: FSM=INIT, counter=0, InReady=0, all OutValid=0, Out ID/value=0, ImproveCount=0, pipeline valids cleared.
REQ-026 Reset asserted mid-INIT or mid-RUN SHALL discard in-flight updates and restart the sweep from address 0 after release.
REQ-027 Memory contents are not reset directly; the INIT sweep defines them.

Structure
REQ-028 Shared package: DATA_W/VID_W defaults, INF constant, FSM state encoding.
REQ-029 One sub-module: vertex_prop_ram (true dual-port, synchronous read, write-first not required).
REQ-030 Hazard forwarding and min compare stay in update_apply_min.

Verification
REQ-031 Reset low 3 cycles, release -> InReady=0 exactly 2^(VID_W-1) cycles then 1; ImproveCount=0.
REQ-032 After init, A=(120,7) one cycle -> 2 cycles later OutValid_A=1, OutDestVid_A=120, OutValue_A=7; ImproveCount=1.
REQ-033 Same cycle A=(120,7), B=(120,5) on fresh memory -> OutValid_A=1 value 5, OutValid_B=0; ImproveCount=1.
REQ-034 Back-to-back A=(40,9), B=(40,4), A=(40,6) -> outputs 9, 4, none; final stored 4; ImproveCount=+2.
REQ-035 Stimulus while InReady=0 (A=(3,1)) -> no output; later A=(3,2) -> OutValue_A=2.
REQ-036 Reset asserted mid-RUN with updates in flight -> no OutValid after release; sweep restarts; earlier values read back as INF.
